reg_dump_streamer: RTL and testbench
====================================

// Module: reg_dump_streamer
// PURPOSE
//  Host-side counterpart of the processor's register-observation outputs.
//  - Snapshots the full register file when the processor pulses instruction_executed.
//  - Streams the snapshot out one word per beat over a valid/ready interface.
//  - Sits between PROCESSOR and the debug/trace link, so register dumps need no simulator $display.
// PARAMETERS
//  NUM_REGS   32   registers per snapshot (index width = $clog2(NUM_REGS))
//  DATA_W     32   register/word width
//  DROP_W     16   width of dropped-snapshot counter
// PORTS
//  clk                   in   1               rising-edge clock
//  rst                   in   1               asynchronous reset, active-high
//  instruction_executed  in   1               snapshot request (level sampled each clk edge)
//  regs_flat             in   NUM_REGS*DATA_W reg0 at [DATA_W-1:0], reg31 at top
//  out_valid             out  1               beat valid
//  out_ready             in   1               sink accepts beat
//  out_data              out  DATA_W          register value (or header word)
//  out_index             out  $clog2(NUM_REGS) register number of current beat
//  out_last              out  1               final beat of snapshot
//  busy                  out  1               snapshot held, not fully sent
//  dropped_cnt           out  DROP_W          snapshots missed while busy (saturating)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, all outputs 0, index 0, seq 0, dropped_cnt 0.
//    Reset mid-stream aborts the dump; no further beats.
//  - FSM: IDLE -> (HDR) -> SEND -> IDLE.
//  - IDLE:
//    - On an edge with instruction_executed=1, latch regs_flat into the shadow bank.
//    - Increment seq (DROP_W bits, wraps), set index=0, go to SEND (HDR when header enabled).
//    - out_valid rises the cycle after the capture edge: one-cycle latency.
//  - SEND:
//    - out_valid=1; out_data=shadow[index]; out_last=(index==NUM_REGS-1).
//    - Handshake occurs on an edge with out_valid&&out_ready.
//      - index<NUM_REGS-1: index++.
//      - index==NUM_REGS-1: go to IDLE.
//  - While out_valid=1 without ready, out_data/out_index/out_last hold stable.
//    out_valid never drops before the handshake.
//  - busy = (state!=IDLE).
//  - Snapshot request while busy, other than the final-beat edge: dropped.
//    - dropped_cnt++, saturating at all-ones.
//    - Shadow bank is not disturbed.
//  - Request on the same edge as the final handshake: accepted.
//    - New capture occurs and the FSM re-enters SEND/HDR directly.
//    - Back-to-back dumps have no idle bubble.
//  - The shadow bank isolates the stream from register changes during the dump.
// CONFIGURATION
//  - `DUMP_HEADER_EN defined:
//    - HDR state emits one beat before reg0.
//    - Header: out_data = {magic 16'hD0C5, seq}, out_index=0, out_last=0. Same valid/ready rules.
//    - Dump = NUM_REGS+1 beats.
//  - Not defined: no HDR state, no seq output; dump = NUM_REGS beats starting at reg0.
// STRUCTURE
//  - Package reg_dump_pkg:
//    - state enum {IDLE, HDR, SEND}
//    - HDR_MAGIC = 16'hD0C5
//    - default NUM_REGS/DATA_W/DROP_W localparams
//  - One sub-module, reg_dump_snapshot: NUM_REGS x DATA_W shadow bank with load enable and a read mux by index.
//  - FSM, counters and handshake stay in the top.
// TESTING
//  1. Reset, regs=i*3, pulse instruction_executed, out_ready=1.
//     -> 32 beats, data 0,3,...,93, out_last on index 31, busy low afterwards.
//  2. Random out_ready stalls.
//     -> data/index stable while stalled; no beat lost or duplicated.
//  3. Change regs_flat during the dump.
//     -> streamed values equal the capture-edge values.
//  4. Pulse at index 10, then a pulse on the final-handshake edge.
//     -> dropped_cnt=1; second dump starts the next cycle with no IDLE bubble.
//  5. Assert rst at index 5 with out_ready=0.
//     -> out_valid=0 immediately; dropped_cnt=0; a new pulse restarts at index 0.
//  6. `DUMP_HEADER_EN, two dumps.
//     -> first beat 32'hD0C5_0001, then 32'hD0C5_0002; 33 beats each.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register-dump streamer.
package reg_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam logic [15:0] HDR_MAGIC = 16'hD0C5;

    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned DROP_W_DEF   = 16;

endpackage

// File: rtl/reg_dump_streamer_if.sv
// Valid/ready beat stream carrying one register word per beat.
interface reg_dump_streamer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 5
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/reg_dump_snapshot.sv
// Shadow register bank: loads the whole register file in one edge, read by index.
module reg_dump_snapshot #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDX_W    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_W-1:0]          rd_data_c
);

    logic [DATA_W-1:0] bank_q [NUM_REGS];
    logic [DATA_W-1:0] bank_d [NUM_REGS];

    // Next bank contents: hold, or capture the full register file.
    always_comb begin
        bank_d = bank_q;
        if (load) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                bank_d[i] = regs_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Bank storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    assign rd_data_c = bank_q[rd_idx];

endmodule

// File: rtl/reg_dump_streamer.sv
// Snapshots the register file on instruction_executed and streams it out
// one word per beat. Define DUMP_HEADER_EN to prepend a {magic, seq} header beat.
module reg_dump_streamer
    import reg_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DROP_W   = DROP_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instruction_executed,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    reg_dump_streamer_if.master        out_if,
    output logic                       busy,
    output logic [DROP_W-1:0]          dropped_cnt
);

    localparam int unsigned      IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic [DROP_W-1:0] drop_q, drop_d;
`ifdef DUMP_HEADER_EN
    logic [DROP_W-1:0] seq_q, seq_d;
`endif

    logic              hs_c;
    logic              accept_c;
    logic              drop_c;
    logic              load_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [DATA_W-1:0] rd_data_c;

    assign hs_c = valid_q && out_if.out_ready;

    // Index of the beat that follows a handshake in the current state.
    assign rd_idx_c = (state_q == SEND) ? idx_q + IDX_W'(1) : '0;

    reg_dump_snapshot #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_snapshot (
        .clk       (clk),
        .rst       (rst),
        .load      (load_c),
        .regs_flat (regs_flat),
        .rd_idx    (rd_idx_c),
        .rd_data_c (rd_data_c)
    );

    // Next state, beat registers, capture/drop decisions.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        last_d   = last_q;
        data_d   = data_q;
        drop_d   = drop_q;
        accept_c = 1'b0;
        drop_c   = 1'b0;
        load_c   = 1'b0;
`ifdef DUMP_HEADER_EN
        seq_d    = seq_q;
`endif

        case (state_q)
            IDLE: begin
                accept_c = instruction_executed;
            end
            HDR: begin
                drop_c = instruction_executed;
                if (hs_c) begin
                    state_d = SEND;
                    idx_d   = rd_idx_c;
                    data_d  = rd_data_c;
                    last_d  = (rd_idx_c == LAST_IDX);
                end
            end
            SEND: begin
                if (hs_c && (idx_q == LAST_IDX)) begin
                    // Final beat: a request on this edge chains straight into a new dump.
                    accept_c = instruction_executed;
                    if (!instruction_executed) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                    end
                end else begin
                    drop_c = instruction_executed;
                    if (hs_c) begin
                        idx_d  = rd_idx_c;
                        data_d = rd_data_c;
                        last_d = (rd_idx_c == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (accept_c) begin
            load_c  = 1'b1;
            idx_d   = '0;
            valid_d = 1'b1;
`ifdef DUMP_HEADER_EN
            seq_d   = seq_q + DROP_W'(1);
            state_d = HDR;
            data_d  = DATA_W'({HDR_MAGIC, seq_d});
            last_d  = 1'b0;
`else
            state_d = SEND;
            data_d  = regs_flat[DATA_W-1:0];
            last_d  = (LAST_IDX == '0);
`endif
        end

        if (drop_c && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
`ifdef DUMP_HEADER_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
`ifdef DUMP_HEADER_EN
            seq_q   <= seq_d;
`endif
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_index = idx_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign dropped_cnt      = drop_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Scoreboard bench for reg_dump_streamer; honours DUMP_HEADER_EN.
module tb_reg_dump_streamer;

    localparam int NR  = 32;
    localparam int DW  = 32;
    localparam int DRW = 16;
    localparam int IW  = 5;
`ifdef DUMP_HEADER_EN
    localparam int HDR_EN = 1;
`else
    localparam int HDR_EN = 0;
`endif
    localparam int BEATS = NR + HDR_EN;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
        logic          hdr;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req = 1'b0;
    logic [NR*DW-1:0]   regs = '0;
    logic               busy;
    logic [DRW-1:0]     dropped_cnt;

    reg_dump_streamer_if #(.DATA_W(DW), .IDX_W(IW)) sif ();

    reg_dump_streamer dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_executed (req),
        .regs_flat            (regs),
        .out_if               (sif),
        .busy                 (busy),
        .dropped_cnt          (dropped_cnt)
    );

    always #5 clk = ~clk;

    beat_t   exp_q[$];
    beat_t   e;
    int      n_chk = 0;
    int      n_fail = 0;
    int      drop_model = 0;
    int      seq_model = 0;

    // Expected beats for a snapshot of the current regs value.
    function automatic void push_dump();
        beat_t b;
        seq_model = (seq_model + 1) % 65536;
        if (HDR_EN != 0) begin
            b.data = {16'hD0C5, 16'(seq_model)};
            b.idx  = '0;
            b.last = 1'b0;
            b.hdr  = 1'b1;
            exp_q.push_back(b);
        end
        for (int i = 0; i < NR; i++) begin
            b.data = regs[i*DW +: DW];
            b.idx  = IW'(i);
            b.last = (i == NR - 1);
            b.hdr  = 1'b0;
            exp_q.push_back(b);
        end
    endfunction

    // Request on the coming edge: accepted only when nothing is outstanding.
    function automatic void request();
        req = 1'b1;
        if (exp_q.size() == 0) push_dump();
        else if (drop_model < 65535) drop_model++;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        sif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (sif.out_valid !== 1'b0 || busy !== 1'b0 || dropped_cnt !== '0 ||
            sif.out_index !== '0 || sif.out_data !== '0 || sif.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b b=%b d=%0d i=%0d data=%h l=%b required all zero",
                     sif.out_valid, busy, dropped_cnt, sif.out_index, sif.out_data, sif.out_last);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int got = 0;
        for (int i = 0; i < NR; i++) regs[i*DW +: DW] = DW'(i * 3);
        @(negedge clk);
        request();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req = 1'b0;
            sif.out_ready = 1'b1;
            if (sif.out_valid) begin
                e = exp_q.pop_front();
                got++;
                n_chk++;
                if (sif.out_data !== e.data || sif.out_index !== e.idx || sif.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL basic_beat got %h/%0d/%b required %h/%0d/%b",
                             sif.out_data, sif.out_index, sif.out_last, e.data, e.idx, e.last);
                end
            end
        end
        @(negedge clk);
        n_chk++;
        if (got !== BEATS || busy !== 1'b0 || sif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end got beats=%0d busy=%b valid=%b required %0d/0/0",
                     got, busy, sif.out_valid, BEATS);
        end
    endtask

    task automatic test_stall(input bit change_regs);
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [IW-1:0] prev_idx = '0;
        logic          prev_last = 1'b0;
        for (int i = 0; i < NR; i++) regs[i*DW +: DW] = $urandom;
        @(negedge clk);
        request();
        for (int c = 0; c < 1000 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (change_regs) for (int i = 0; i < NR; i++) regs[i*DW +: DW] = $urandom;
            if (prev_stall) begin
                n_chk++;
                if (sif.out_valid !== 1'b1 || sif.out_data !== prev_data ||
                    sif.out_index !== prev_idx || sif.out_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_hold got %b/%h/%0d/%b required 1/%h/%0d/%b",
                             sif.out_valid, sif.out_data, sif.out_index, sif.out_last,
                             prev_data, prev_idx, prev_last);
                end
            end
            sif.out_ready = ($urandom_range(0, 2) != 0);
            if (sif.out_valid && sif.out_ready) begin
                e = exp_q.pop_front();
                n_chk++;
                if (sif.out_data !== e.data || sif.out_index !== e.idx || sif.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL stall_beat got %h/%0d/%b required %h/%0d/%b",
                             sif.out_data, sif.out_index, sif.out_last, e.data, e.idx, e.last);
                end
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_data  = sif.out_data;
            prev_idx   = sif.out_index;
            prev_last  = sif.out_last;
        end
        sif.out_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end got left=%0d busy=%b required 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        bit chained = 1'b0;
        bit check_next = 1'b0;
        for (int i = 0; i < NR; i++) regs[i*DW +: DW] = $urandom;
        @(negedge clk);
        request();
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req = 1'b0;
            sif.out_ready = 1'b1;
            if (check_next) begin
                check_next = 1'b0;
                n_chk++;
                if (sif.out_valid !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL no_bubble got valid=%b busy=%b required 1/1", sif.out_valid, busy);
                end
            end
            if (sif.out_valid) begin
                e = exp_q.pop_front();
                n_chk++;
                if (sif.out_data !== e.data || sif.out_index !== e.idx || sif.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL b2b_beat got %h/%0d/%b required %h/%0d/%b",
                             sif.out_data, sif.out_index, sif.out_last, e.data, e.idx, e.last);
                end
                if (!chained && !e.hdr && e.idx == 5'd10) request();
                if (!chained && e.last) begin
                    for (int i = 0; i < NR; i++) regs[i*DW +: DW] = $urandom;
                    request();
                    chained = 1'b1;
                    check_next = 1'b1;
                end
            end
        end
        @(negedge clk);
        n_chk++;
        if (dropped_cnt !== DRW'(drop_model) || drop_model != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_dropped got %0d left=%0d busy=%b required %0d/0/0",
                     dropped_cnt, exp_q.size(), busy, drop_model);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int i = 0; i < NR; i++) regs[i*DW +: DW] = $urandom;
        @(negedge clk);
        request();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (sif.out_valid && exp_q.size() != 0 && exp_q[0].idx == 5'd5 && !exp_q[0].hdr) begin
                sif.out_ready = 1'b0;
                found = 1'b1;
                break;
            end
            sif.out_ready = 1'b1;
            if (sif.out_valid) begin
                e = exp_q.pop_front();
                n_chk++;
                if (sif.out_data !== e.data || sif.out_index !== e.idx) begin
                    n_fail++;
                    $display("FAIL rstmid_beat got %h/%0d required %h/%0d",
                             sif.out_data, sif.out_index, e.data, e.idx);
                end
            end
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_reach got no index-5 beat required one");
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (sif.out_valid !== 1'b0 || dropped_cnt !== '0 || sif.out_index !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async got v=%b d=%0d i=%0d b=%b required 0/0/0/0",
                     sif.out_valid, dropped_cnt, sif.out_index, busy);
        end
        exp_q.delete();
        drop_model = 0;
        seq_model = 0;
        @(negedge clk);
        n_chk++;
        if (sif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_hold got valid=%b required 0", sif.out_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        request();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req = 1'b0;
            sif.out_ready = 1'b1;
            if (sif.out_valid) begin
                e = exp_q.pop_front();
                n_chk++;
                if (sif.out_data !== e.data || sif.out_index !== e.idx || sif.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL restart_beat got %h/%0d/%b required %h/%0d/%b",
                             sif.out_data, sif.out_index, sif.out_last, e.data, e.idx, e.last);
                end
            end
        end
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_end got left=%0d busy=%b required 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_header();
        rst = 1'b1;
        exp_q.delete();
        drop_model = 0;
        seq_model = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 1; d <= 2; d++) begin
            int got = 0;
            bit first = 1'b1;
            logic [DW-1:0] first_exp;
            for (int i = 0; i < NR; i++) regs[i*DW +: DW] = $urandom;
            first_exp = (HDR_EN != 0) ? {16'hD0C5, 16'(d)} : regs[DW-1:0];
            @(negedge clk);
            request();
            for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
                @(negedge clk);
                req = 1'b0;
                sif.out_ready = 1'b1;
                if (sif.out_valid) begin
                    if (first) begin
                        first = 1'b0;
                        n_chk++;
                        if (sif.out_data !== first_exp) begin
                            n_fail++;
                            $display("FAIL hdr_first got %h required %h", sif.out_data, first_exp);
                        end
                    end
                    e = exp_q.pop_front();
                    got++;
                    n_chk++;
                    if (sif.out_data !== e.data || sif.out_index !== e.idx || sif.out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL hdr_beat got %h/%0d/%b required %h/%0d/%b",
                                 sif.out_data, sif.out_index, sif.out_last, e.data, e.idx, e.last);
                    end
                end
            end
            @(negedge clk);
            n_chk++;
            if (got != BEATS || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL hdr_count got %0d busy=%b required %0d/0", got, busy, BEATS);
            end
        end
    endtask

    initial begin
        sif.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall(1'b0);
        test_stall(1'b1);
        test_back_to_back();
        test_reset_mid();
        test_header();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
